// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_D  = 32;
  localparam int unsigned NREGS_D = 32;
  localparam int unsigned NRD_D   = 2;

  // IDLE: normal operation; CLEAR: zeroing sweep over regs 1..NREGS-1
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-result scoreboard: one bit per register.
// Ports: clk, rst (async, active-high), flush (zero all bits),
//        set_en/set_a (reserve), clr_en/clr_a (accepted write), bits (state).
// Priority: flush > set > clear, so a same-cycle reserve and write keeps the bit.
module regfile_scoreboard #(
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             set_en,
  input  logic [AW-1:0]    set_a,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_a,
  output logic [NREGS-1:0] bits
);

  logic [NREGS-1:0] bits_nxt;

  // next pend state; register 0 can never be pending
  always_comb begin
    bits_nxt = bits;
    if (flush) begin
      bits_nxt = '0;
    end else begin
      if (clr_en) bits_nxt[clr_a] = 1'b0;
      if (set_en) bits_nxt[set_a] = 1'b1;
    end
    bits_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bits <= '0;
    else     bits <= bits_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional write forwarding, a pend
// scoreboard and a self-clearing sweep (run after reset and on clr_req).
// Ports: clk, rst (async, active-high); we/wa/wd write port;
//        ra/rd packed read ports (port i at [i*AW +: AW] / [i*XLEN +: XLEN]);
//        rsv_en/rsv_a reserve; pend per read port; clr_req sweep request;
//        busy high while sweeping.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_D,
  parameter int unsigned NREGS  = NREGS_D,
  parameter int unsigned NRD    = NRD_D,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_a,
  output logic [NRD-1:0]      pend,
  input  logic                clr_req,
  output logic                busy
);

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             sweep_wr;
  logic             flush;
  logic             wr_en;
  logic             rsv_ok;
  logic [NREGS-1:0] pend_bits;
  logic [XLEN-1:0]  mem [NREGS];
  logic [AW-1:0]    a;

  assign busy   = (state_q == CLEAR);
  assign wr_en  = we && (wa != '0) && !busy;
  assign rsv_ok = rsv_en && (rsv_a != '0) && !busy;

  // state register; reset restarts the sweep from register 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_wr = 1'b0;
    flush    = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = AW'(1);
          flush   = 1'b1;
        end
      end
      CLEAR: begin
        sweep_wr = 1'b1;
        cnt_d    = cnt_q + AW'(1);
        if (cnt_q == AW'(NREGS - 1)) state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  // data array is never reset; the sweep is what zeroes it
  always_ff @(posedge clk) begin
    if (sweep_wr)   mem[cnt_q] <= '0;
    else if (wr_en) mem[wa]    <= wd;
  end

  regfile_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .set_en (rsv_ok),
    .set_a  (rsv_a),
    .clr_en (wr_en),
    .clr_a  (wa),
    .bits   (pend_bits)
  );

  // combinational read ports; all outputs masked while sweeping
  always_comb begin
    rd   = '0;
    pend = '0;
    a    = '0;
    for (int i = 0; i < int'(NRD); i++) begin
      a = ra[i*AW +: AW];
      if (!busy) begin
        pend[i] = pend_bits[a];
        if ((BYPASS != 0) && wr_en && (wa == a)) rd[i*XLEN +: XLEN] = wd;
        else if (a != '0)                        rd[i*XLEN +: XLEN] = mem[a];
      end
    end
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count, power of two, at least 4; AW = clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports, 1 to 4.
REQ-004 SHALL have parameter BYPASS, default 1; 1 = write-to-read forwarding enabled.
REQ-005 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port we  in  1  write enable.
REQ-008 SHALL have port wa  in  AW  write address.
REQ-009 SHALL have port wd  in  XLEN  write data.
REQ-010 SHALL have port ra  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
REQ-011 SHALL have port rd  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
REQ-012 SHALL have port rsv_en  in  1  reserve request: marks a register as pending a result.
REQ-013 SHALL have port rsv_a  in  AW  address to reserve.
REQ-014 SHALL have port pend  out  NRD  pend[i] is the pending bit of ra port i.
REQ-015 SHALL have port clr_req  in  1  request a full clear sweep.
REQ-016 SHALL have port busy  out  1  clear sweep in progress.

Function
REQ-017 Register 0 SHALL read as 0 and never be written; reserving address 0 SHALL be ignored.
REQ-018 Reads SHALL be combinational: rd[i] = reg[ra[i]] in the same cycle.
REQ-019 A write SHALL update reg[wa] at the clock edge when we=1, wa!=0 and busy=0.
REQ-020 With BYPASS=1, when we=1, wa!=0, wa==ra[i] and busy=0, rd[i] SHALL equal wd in the same cycle.
REQ-021 With BYPASS=0, rd[i] SHALL show the old value until the edge after the write.
REQ-022 The FSM SHALL have states IDLE and CLEAR, held with a counter cnt of AW bits.
REQ-023 IDLE with clr_req=1 SHALL move to CLEAR with cnt=1.
REQ-024 Each CLEAR cycle SHALL write 0 to reg[cnt], then increment cnt; the state SHALL return to IDLE after the write with cnt=NREGS-1.
REQ-025 A sweep SHALL last exactly NREGS-1 cycles with busy=1, and busy SHALL be 0 the cycle after.
REQ-026 While busy=1: we, rsv_en and clr_req SHALL be ignored, all rd SHALL be 0, and all pend SHALL be 0.
REQ-027 The scoreboard SHALL hold one pend bit per register, set at the edge when rsv_en=1 and rsv_a!=0.
REQ-028 A pend bit SHALL clear at the edge when an accepted write (REQ-019) targets that register.
REQ-029 If a reserve and a write hit the same register in the same cycle, the reserve SHALL win and the bit SHALL stay 1.
REQ-030 pend[i] SHALL be combinational from the pend bit of ra[i]; there SHALL be no bypass on pend.
REQ-031 Entry into CLEAR SHALL zero all pend bits at that edge.

Reset
REQ-032 Reset assertion SHALL immediately force state=CLEAR, cnt=1, all pend bits=0 and busy=1.
REQ-033 The data array SHALL NOT be reset directly; the post-reset sweep clears it.
REQ-034 Reset asserted mid-sweep SHALL restart the sweep from cnt=1.

Structure
REQ-035 Package regfile_pkg SHALL hold the state enum (IDLE, CLEAR) and the default values XLEN_D=32, NREGS_D=32 and NRD_D=2.
REQ-036 The pend-bit array and its set/clear priority logic SHALL be sub-module regfile_scoreboard, with parameter NREGS.

Verification
REQ-037 Reset is released -> busy=1 for 31 cycles, then 0; every rd reads 0 and no pend is set.
REQ-038 we=1, wa=5, wd=0xDEADBEEF with ra0=5 and BYPASS=1 -> rd0=0xDEADBEEF the same cycle. With BYPASS=0 -> rd0=0 that cycle and 0xDEADBEEF the next.
REQ-039 Write wa=0, wd=0x1234 -> reading ra=0 returns 0. Reserve rsv_a=0 -> pend for ra=0 stays 0.
REQ-040 Reserve reg 7, then three cycles later write reg 7 with 0x55 -> pend0 (ra0=7) is 1 for three cycles, then 0. A same-cycle reserve plus write to reg 7 -> pend stays 1 and data becomes 0x55.
REQ-041 Write regs 1..31 with i*0x11111111, then pulse clr_req -> busy=1 for 31 cycles; a write to reg 3 during the sweep is dropped; all regs read 0 afterwards.
REQ-042 rst is pulsed at sweep cycle 10 -> busy stays 1 for 31 cycles after release, and all regs read 0 afterwards.
